serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It processes one bit per clock, LSB first, and produces a WIDTH-bit result with carry-out and signed overflow. A start/done handshake makes it the multi-cycle, area-minimal successor to the team's single-bit combinational full adder. It sits in the datapath wherever a narrow adder must be shared across wide operands.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_adder.sv | 91 +++++++++
 tb/tb_serial_adder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and counter sizing shared by the serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational one-bit full adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one bit per clock LSB first, with start/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int            CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_op_a, r_op_b, r_shift, r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_c_msb_in, r_cout, r_overflow;
   logic             w_s, w_co, w_last;

   fa_cell u_fa (
      .a  (r_op_a[0]),
      .b  (r_op_b[0]),
      .cin(r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_last   = r_cnt == LAST;
   assign busy     = r_state != IDLE;
   assign done     = r_state == DONE;
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_overflow;

   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? RUN : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         default: w_next = IDLE;
      endcase
   end

   // Subtraction reuses the adder as a + ~b + ~cin; the inversion is folded in at load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_c_msb_in <= 1'b0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_op_a  <= a;
         r_op_b  <= sub ? ~b : b;
         r_carry <= cin ^ sub;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_op_a  <= r_op_a >> 1;
         r_op_b  <= r_op_b >> 1;
         r_carry <= w_co;
         r_shift <= {w_s, r_shift[WIDTH-1:1]};
         if (!w_last) r_cnt <= r_cnt + 1'b1;
         if (r_cnt == PENULT) r_c_msb_in <= w_co;
         if (w_last) begin
            r_sum      <= {w_s, r_shift[WIDTH-1:1]};
            r_cout     <= w_co;
            r_overflow <= w_co ^ r_c_msb_in;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks serial_adder at WIDTH 8, 2 and 13 against an arithmetic reference model.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cin = 1'b0, sub = 1'b0;
   logic st8 = 1'b0, st2 = 1'b0, st13 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, sum8;
   logic [1:0]  a2 = '0, b2 = '0, sum2;
   logic [12:0] a13 = '0, b13 = '0, sum13;
   logic busy8, done8, cout8, ov8;
   logic busy2, done2, cout2, ov2;
   logic busy13, done13, cout13, ov13;
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(cin), .sub(sub),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8));

   serial_adder #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .cin(cin), .sub(sub),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ov2));

   serial_adder #(.WIDTH(13)) u_dut13 (
      .clk(clk), .rst(rst), .start(st13), .a(a13), .b(b13), .cin(cin), .sub(sub),
      .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .overflow(ov13));

   function automatic logic busy_of(input int w);
      return (w == 2) ? busy2 : (w == 13) ? busy13 : busy8;
   endfunction

   function automatic logic done_of(input int w);
      return (w == 2) ? done2 : (w == 13) ? done13 : done8;
   endfunction

   function automatic logic [63:0] sum_of(input int w);
      return (w == 2) ? 64'(sum2) : (w == 13) ? 64'(sum13) : 64'(sum8);
   endfunction

   function automatic logic cout_of(input int w);
      return (w == 2) ? cout2 : (w == 13) ? cout13 : cout8;
   endfunction

   function automatic logic ov_of(input int w);
      return (w == 2) ? ov2 : (w == 13) ? ov13 : ov8;
   endfunction

   // Reference: exact integer arithmetic, then reduce to WIDTH bits.
   function automatic void model(input int w, input logic [63:0] a_i, b_i, input logic cin_i, sub_i,
                                 output logic [63:0] s, output logic co, output logic ov);
      longint m  = longint'(1) << w;
      longint ua = longint'(a_i);
      longint ub = longint'(b_i);
      longint ci = cin_i ? 1 : 0;
      longint sa = (ua >= m / 2) ? ua - m : ua;
      longint sb = (ub >= m / 2) ? ub - m : ub;
      longint r  = sub_i ? ua - ub - ci : ua + ub + ci;
      longint sr = sub_i ? sa - sb - ci : sa + sb + ci;
      s  = 64'(r & (m - 1));
      co = sub_i ? (r >= 0) : (r >= m);
      ov = (sr < -(m / 2)) || (sr >= m / 2);
   endfunction

   task automatic run_op(input int w, input logic [63:0] a_i, b_i, input logic cin_i, sub_i,
                         output int lat, output int busy_n, output int done_n);
      cin = cin_i;
      sub = sub_i;
      case (w)
         2:       begin a2  = a_i[1:0];  b2  = b_i[1:0];  st2  = 1'b1; end
         13:      begin a13 = a_i[12:0]; b13 = b_i[12:0]; st13 = 1'b1; end
         default: begin a8  = a_i[7:0];  b8  = b_i[7:0];  st8  = 1'b1; end
      endcase
      @(posedge clk); #1;
      st2 = 1'b0; st8 = 1'b0; st13 = 1'b0;
      lat = -1; busy_n = 0; done_n = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy_of(w)) busy_n++;
         if (done_of(w)) begin
            done_n++;
            if (lat < 0) lat = k;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({busy8, done8, cout8, ov8} !== 4'b0 || sum8 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_w8: busy=%b done=%b sum=%h cout=%b ov=%b expected all zero", busy8, done8, sum8, cout8, ov8);
      end
      n_tests++;
      if ({busy2, done2, cout2, ov2, sum2} !== 6'b0 || {busy13, done13, cout13, ov13, sum13} !== 17'b0) begin
         n_fail++;
         $display("FAIL reset_w2_w13: w2=%b%b%b%b%h w13=%b%b%b%b%h expected all zero",
                  busy2, done2, cout2, ov2, sum2, busy13, done13, cout13, ov13, sum13);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_basic;
      int lat, bn, dn;
      run_op(8, 64'h0F, 64'h01, 1'b0, 1'b0, lat, bn, dn);
      n_tests++;
      if ({sum8, cout8, ov8} !== {8'h10, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL add_basic_result: got sum=%h cout=%b ov=%b expected 10 0 0", sum8, cout8, ov8);
      end
      n_tests++;
      if (lat !== 8 || dn !== 1) begin
         n_fail++;
         $display("FAIL add_basic_done: got done at sample %0d width %0d expected 8 and 1", lat, dn);
      end
      n_tests++;
      if (bn !== 9) begin
         n_fail++;
         $display("FAIL add_basic_busy: got %0d busy cycles expected 9", bn);
      end
   endtask

   task automatic test_vectors;
      logic [7:0] ta[4]  = '{8'hFF, 8'h7F, 8'h05, 8'h80};
      logic [7:0] tb_[4] = '{8'h01, 8'h01, 8'h07, 8'h01};
      logic       tc[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic       ts[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [9:0] exp[4] = '{{8'h01, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1},
                             {8'hFE, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1}};
      int lat, bn, dn;
      for (int i = 0; i < 4; i++) begin
         run_op(8, 64'(ta[i]), 64'(tb_[i]), tc[i], ts[i], lat, bn, dn);
         n_tests++;
         if ({sum8, cout8, ov8} !== exp[i] || lat !== 8) begin
            n_fail++;
            $display("FAIL vector_%0d: got sum=%h cout=%b ov=%b lat=%0d expected %h %b %b lat=8",
                     i, sum8, cout8, ov8, lat, exp[i][9:2], exp[i][1], exp[i][0]);
         end
      end
   endtask

   task automatic test_ignore_start;
      int lat = -1, dn = 0;
      logic hold_bad = 1'b0;
      cin = 1'b0; sub = 1'b0; a8 = 8'h01; b8 = 8'h01; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k == 3) begin a8 = 8'h11; b8 = 8'h22; st8 = 1'b1; end
         if (k == 4) st8 = 1'b0;
         if (done8) begin dn++; if (lat < 0) lat = k; end
         @(posedge clk); #1;
      end
      n_tests++;
      if (sum8 !== 8'h02 || dn !== 1 || lat !== 8) begin
         n_fail++;
         $display("FAIL ignore_start: got sum=%h dones=%0d lat=%0d expected 02 1 8", sum8, dn, lat);
      end
      a8 = 8'h10; b8 = 8'h20; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k < 8 && sum8 !== 8'h02) hold_bad = 1'b1;
         @(posedge clk); #1;
      end
      n_tests++;
      if (hold_bad) begin
         n_fail++;
         $display("FAIL sum_hold: sum changed during next RUN, expected 02 held");
      end
      n_tests++;
      if (sum8 !== 8'h30) begin
         n_fail++;
         $display("FAIL sum_after_hold: got %h expected 30", sum8);
      end
   endtask

   task automatic test_abort;
      int dn = 0, lat, bn;
      cin = 1'b0; sub = 1'b0; a8 = 8'hAA; b8 = 8'h11; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_tests++;
      if ({busy8, done8, cout8, ov8} !== 4'b0 || sum8 !== 8'h00) begin
         n_fail++;
         $display("FAIL abort_reset: busy=%b done=%b sum=%h cout=%b ov=%b expected all zero", busy8, done8, sum8, cout8, ov8);
      end
      for (int k = 0; k < 20; k++) begin
         if (done8) dn++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (dn !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d done pulses expected 0", dn);
      end
      a8 = 8'h09; b8 = 8'h09; st8 = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (busy8 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_beats_start: got busy=%b expected 0", busy8);
      end
      run_op(8, 64'h03, 64'h04, 1'b0, 1'b0, lat, bn, dn);
      n_tests++;
      if (sum8 !== 8'h07 || lat !== 8) begin
         n_fail++;
         $display("FAIL after_abort: got sum=%h lat=%0d expected 07 8", sum8, lat);
      end
   endtask

   task automatic test_back_to_back;
      int d1 = -1, d2 = -1;
      logic [9:0] r1 = '0, r2 = '0;
      logic idle9 = 1'b0;
      cin = 1'b0; sub = 1'b0; a8 = 8'h10; b8 = 8'h05; st8 = 1'b1;
      @(posedge clk); #1;
      a8 = 8'h20; b8 = 8'h03; sub = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (k == 9) idle9 = ~busy8;
         if (k == 10) st8 = 1'b0;
         if (done8 && d1 < 0) begin d1 = k; r1 = {sum8, cout8, ov8}; end
         else if (done8 && d2 < 0) begin d2 = k; r2 = {sum8, cout8, ov8}; end
         @(posedge clk); #1;
      end
      st8 = 1'b0;
      n_tests++;
      if (d1 !== 8 || r1 !== {8'h15, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_first: got done@%0d res=%h expected done@8 res=%h", d1, r1, {8'h15, 2'b00});
      end
      n_tests++;
      if (d2 !== 18 || r2 !== {8'h1D, 1'b1, 1'b0} || !idle9) begin
         n_fail++;
         $display("FAIL b2b_second: got done@%0d res=%h idle9=%b expected done@18 res=%h idle9=1",
                  d2, r2, idle9, {8'h1D, 2'b10});
      end
   endtask

   task automatic test_w2_exhaustive;
      logic [63:0] es;
      logic ec, eo;
      int lat, bn, dn;
      for (int i = 0; i < 64; i++) begin
         logic [5:0] v = 6'(i);
         run_op(2, 64'(v[1:0]), 64'(v[3:2]), v[4], v[5], lat, bn, dn);
         model(2, 64'(v[1:0]), 64'(v[3:2]), v[4], v[5], es, ec, eo);
         n_tests++;
         if (sum_of(2) !== es || cout_of(2) !== ec || ov_of(2) !== eo || lat !== 2) begin
            n_fail++;
            $display("FAIL w2_case_%0d: got sum=%0h cout=%b ov=%b lat=%0d expected %0h %b %b lat=2",
                     i, sum_of(2), cout_of(2), ov_of(2), lat, es, ec, eo);
         end
      end
   endtask

   task automatic test_w13_random;
      logic [63:0] ra, rb, es;
      logic rc, rs, ec, eo;
      int lat, bn, dn;
      for (int i = 0; i < 1000; i++) begin
         ra = 64'($urandom_range(8191));
         rb = 64'($urandom_range(8191));
         rc = 1'($urandom_range(1));
         rs = 1'($urandom_range(1));
         run_op(13, ra, rb, rc, rs, lat, bn, dn);
         model(13, ra, rb, rc, rs, es, ec, eo);
         n_tests++;
         if (sum_of(13) !== es || cout_of(13) !== ec || ov_of(13) !== eo || lat !== 13) begin
            n_fail++;
            $display("FAIL w13_rand_%0d: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ov=%b lat=%0d expected %h %b %b lat=13",
                     i, ra, rb, rc, rs, sum_of(13), cout_of(13), ov_of(13), lat, es, ec, eo);
         end
      end
   endtask

   initial begin
      test_reset;
      test_add_basic;
      test_vectors;
      test_ignore_start;
      test_abort;
      test_back_to_back;
      test_w2_exhaustive;
      test_w13_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
